hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
Stall/flush controller for the 5-stage RISC-V pipeline. It is the counterpart to forwarding, which resolves most EX-stage operand hazards by bypassing.
- Detects what bypassing cannot fix: load-use RAW hazards, hazards against a multi-cycle mul/div unit (result not bypassable), and structural conflicts on that unit.
- Emits PC/IF-ID write enables, ID/EX bubble, and branch flushes.
- Sits beside the ID stage and holds a one-entry scoreboard FSM for the mul/div unit.

Parameters:
- MD_LATENCY, 4, cycles mul/div spends in BUSY (min 1).
- CNT_W, $clog2(MD_LATENCY)+1, busy-counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ifId_Rs1, ifId_Rs2  in  5 each  ID-stage source registers
- ifId_UsesRs1, ifId_UsesRs2  in  1 each  ID instruction reads Rs1/Rs2
- ifId_Rd  in  5  ID-stage destination
- ifId_RegWrite  in  1  ID instruction writes Rd
- ifId_MdOp  in  1  ID instruction is mul/div
- idEx_Rd  in  5  EX-stage destination
- idEx_MemRead  in  1  EX instruction is a load
- idEx_MdOp  in  1  EX instruction is mul/div (issue point)
- ex_BranchTaken  in  1  branch/jump resolved taken in EX
- pc_Write  out  1  PC update enable
- ifId_Write  out  1  IF/ID register enable
- idEx_Bubble  out  1  zero control bits entering ID/EX
- ifId_Flush  out  1  clear IF/ID
- idEx_Flush  out  1  clear ID/EX
- md_busy  out  1  mul/div occupied
- md_done  out  1  one-cycle writeback strobe
- md_Rd  out  5  destination of the in-flight mul/div

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W], md_Rd.
- Reset (rst_n=0 at posedge): state=IDLE, cnt=0, md_Rd=0. md_busy and md_done are 0 after reset.
- Reset mid-operation: the operation is abandoned, with no md_done pulse.
- IDLE & idEx_MdOp: capture md_Rd<=idEx_Rd, cnt<=MD_LATENCY-1, go to BUSY.
- BUSY: cnt decrements each cycle. At cnt==0, go to DONE.
- DONE: lasts exactly 1 cycle, then IDLE. md_done=1 only in DONE; md_Rd is valid for the writeback.
- Latency: issue edge to the md_done cycle is MD_LATENCY+1 cycles.
- md_busy=1 in BUSY and DONE.
- idEx_MdOp while not IDLE is ignored. This cannot occur legally; the bench asserts it never occurs.
- Pending register: md_Rd while state!=IDLE and md_Rd!=0. The rd=x0 case still occupies the unit.
- Stall conditions (combinational, OR-ed):
  - load_use: idEx_MemRead & idEx_Rd!=0 & ((UsesRs1 & Rs1==idEx_Rd) | (UsesRs2 & Rs2==idEx_Rd)).
  - md_raw: pending & a used source equals md_Rd.
  - md_waw: pending & ifId_RegWrite & ifId_Rd==md_Rd.
  - md_struct: ifId_MdOp & state!=IDLE.
- On stall: pc_Write=0, ifId_Write=0, idEx_Bubble=1. Otherwise pc_Write=ifId_Write=1, idEx_Bubble=0.
- ex_BranchTaken has priority over stall: ifId_Flush=1, idEx_Flush=1, pc_Write=1, ifId_Write=1, idEx_Bubble=0.
- Flush outputs are otherwise 0.
- A branch in EX does not cancel the scoreboard; the mul/div is older than the branch.
- Simultaneous DONE and ID hazard on md_Rd: still stall in DONE. Release occurs the cycle after, when the register file holds the value.
- Simultaneous load_use and md hazards: single stall, same outputs.
- All pipeline-control outputs are combinational from inputs plus registered state. There are no combinational loops.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output stall_cycles[31:0].
  - Increments on each cycle with stall asserted and ex_BranchTaken=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg: state enum (IDLE/BUSY/DONE), REG_X0=5'd0, MD_LATENCY_DEFAULT=4.
- Sub-module md_scoreboard: FSM, counter and md_Rd register. Outputs busy/done/pending/md_Rd.
- Top level: stall/flush combinational logic plus the optional perf counter.

Test Plan:
- Load-use: idEx_MemRead=1, idEx_Rd=5, ifId_Rs1=5, UsesRs1=1 -> pc_Write=0, ifId_Write=0, idEx_Bubble=1 for exactly 1 cycle. With idEx_Rd=0 -> no stall.
- Mul/div latency: idEx_MdOp=1, idEx_Rd=7 at cycle 0 -> md_busy=1 from cycle 1. md_done=1 and md_Rd=7 in cycle 5 only (MD_LATENCY=4). IDLE in cycle 6.
- md RAW/WAW/struct: while busy with rd=7, ID uses Rs2=7, or writes Rd=7, or issues MdOp -> stall each cycle through DONE, release in cycle 6. Unrelated rd=8 -> no stall.
- Branch priority: load_use condition plus ex_BranchTaken=1 -> ifId_Flush=idEx_Flush=1, pc_Write=1, idEx_Bubble=0. Scoreboard unaffected.
- Reset mid-op: rst_n=0 at cycle 2 of BUSY -> next cycle state IDLE, md_busy=0, md_Rd=0, no md_done pulse.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 5 md stall cycles -> stall_cycles=8. Flush cycles are not counted.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard control unit.
//   md_state_t          : mul/div scoreboard FSM states (IDLE/BUSY/DONE)
//   REG_X0              : architectural zero register index
//   MD_LATENCY_DEFAULT  : default mul/div BUSY duration in cycles
//   src_match()         : "this source operand is read and names rd"
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [4:0]  REG_X0             = 5'd0;
    localparam int unsigned MD_LATENCY_DEFAULT = 4;

    function automatic logic src_match(input logic       uses,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_control_unit_md_scoreboard.sv
// md_scoreboard
// One-entry scoreboard for the multi-cycle mul/div unit.
//   clk, rst_n  : clock, synchronous active-low reset
//   issue       : mul/div instruction entering EX (accepted only in IDLE)
//   issue_rd    : its destination register
//   busy        : unit occupied (BUSY or DONE)
//   done        : one-cycle writeback strobe (DONE state)
//   pending     : md_rd is still unwritten and is not x0
//   md_rd       : destination of the in-flight operation
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic [4:0] issue_rd,
    output logic       busy,
    output logic       done,
    output logic       pending,
    output logic [4:0] md_rd
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY) + 1;

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;

    // BUSY lasts MD_LATENCY cycles: cnt is loaded with MD_LATENCY-1 and
    // the DONE transition is taken on the cycle cnt reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            md_rd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        md_rd <= issue_rd;
                        cnt   <= CNT_W'(MD_LATENCY - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        // x0 never carries a value, so it never blocks a reader or writer.
        pending = busy && (md_rd != REG_X0);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Stall/flush controller for the 5-stage RISC-V pipeline. Detects hazards
// that forwarding cannot resolve (load-use, mul/div RAW/WAW, mul/div
// structural) and steers PC/IF-ID enables, ID/EX bubble and branch flushes.
//   clk, rst_n                    : clock, synchronous active-low reset
//   ifId_Rs1/Rs2, UsesRs1/UsesRs2 : ID-stage source operands
//   ifId_Rd, ifId_RegWrite        : ID-stage destination
//   ifId_MdOp                     : ID instruction is mul/div
//   idEx_Rd, idEx_MemRead         : EX-stage destination / load flag
//   idEx_MdOp                     : EX instruction is mul/div (issue point)
//   ex_BranchTaken                : branch/jump taken in EX
//   pc_Write, ifId_Write          : pipeline front-end enables
//   idEx_Bubble                   : zero control bits entering ID/EX
//   ifId_Flush, idEx_Flush        : branch flush controls
//   md_busy, md_done, md_Rd       : mul/div scoreboard status
// Optional: HAZARD_PERF_CNT_EN adds stall_cycles[31:0], a saturating count
// of stalled cycles that were not overridden by a taken branch.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ifId_Rs1,
    input  logic [4:0]  ifId_Rs2,
    input  logic        ifId_UsesRs1,
    input  logic        ifId_UsesRs2,
    input  logic [4:0]  ifId_Rd,
    input  logic        ifId_RegWrite,
    input  logic        ifId_MdOp,
    input  logic [4:0]  idEx_Rd,
    input  logic        idEx_MemRead,
    input  logic        idEx_MdOp,
    input  logic        ex_BranchTaken,
    output logic        pc_Write,
    output logic        ifId_Write,
    output logic        idEx_Bubble,
    output logic        ifId_Flush,
    output logic        idEx_Flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [4:0]  md_Rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic md_pending;
    logic load_use;
    logic md_raw;
    logic md_waw;
    logic md_struct;
    logic stall;

    md_scoreboard #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (idEx_MdOp),
        .issue_rd (idEx_Rd),
        .busy     (md_busy),
        .done     (md_done),
        .pending  (md_pending),
        .md_rd    (md_Rd)
    );

    // Pending stays true through DONE: the register file is only written
    // at the end of DONE, so readers are released the cycle after.
    always_comb begin
        load_use  = idEx_MemRead && (idEx_Rd != REG_X0) &&
                    (src_match(ifId_UsesRs1, ifId_Rs1, idEx_Rd) ||
                     src_match(ifId_UsesRs2, ifId_Rs2, idEx_Rd));
        md_raw    = md_pending &&
                    (src_match(ifId_UsesRs1, ifId_Rs1, md_Rd) ||
                     src_match(ifId_UsesRs2, ifId_Rs2, md_Rd));
        md_waw    = md_pending && ifId_RegWrite && (ifId_Rd == md_Rd);
        md_struct = ifId_MdOp && md_busy;
        stall     = load_use || md_raw || md_waw || md_struct;
    end

    // A taken branch squashes the stalled instruction anyway, so it wins
    // and lets the PC move to the branch target.
    always_comb begin
        pc_Write    = 1'b1;
        ifId_Write  = 1'b1;
        idEx_Bubble = 1'b0;
        ifId_Flush  = 1'b0;
        idEx_Flush  = 1'b0;
        if (ex_BranchTaken) begin
            ifId_Flush = 1'b1;
            idEx_Flush = 1'b1;
        end else if (stall) begin
            pc_Write    = 1'b0;
            ifId_Write  = 1'b0;
            idEx_Bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !ex_BranchTaken && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule
